// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default constants for the UART transmitter
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_FIFO_DEPTH = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wr_data,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign rd_data = mem[rd_ptr];
    // storage is deliberately left out of reset
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wr_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 serial transmitter fed from a byte FIFO
module uart_tx_fifo import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    tx_state_t state, state_n;
    logic [15:0] baud, baud_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shreg, shreg_n, head;
    logic tx_n, pop, full, empty, last;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(in_valid),
        .pop(pop),
        .wr_data(in_data),
        .rd_data(head),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );

    assign in_ready = ~full;
    assign busy = state != IDLE;
    assign last = baud == 16'(CLKS_PER_BIT - 1);

    always_comb begin
        state_n = state;
        bit_n = bit_idx;
        shreg_n = shreg;
        pop = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                state_n = START;
                pop = 1'b1;
                shreg_n = head;
            end
            START: if (last) begin
                state_n = DATA;
                bit_n = '0;
            end
            DATA: if (last) begin
                shreg_n = shreg >> 1;
                bit_n = bit_idx + 3'd1;
                state_n = bit_idx == 3'd7 ? STOP : DATA;
            end
            STOP: if (last) begin
                state_n = empty ? IDLE : START;
                pop = ~empty;
                shreg_n = empty ? shreg : head;
            end
            default: state_n = IDLE;
        endcase
        baud_n = (state == IDLE || last) ? '0 : baud + 16'd1;
        // tx is registered, so it follows the state being entered
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            baud <= '0;
            bit_idx <= '0;
            shreg <= '0;
            tx <= 1'b1;
        end else begin
            state <= state_n;
            baud <= baud_n;
            bit_idx <= bit_n;
            shreg <= shreg_n;
            tx <= tx_n;
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed checks against a frame-position model
module tb_uart_tx_fifo;
    localparam int C = 4;
    localparam int D = 4;
    localparam int FL = 10 * C;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready, tx, busy;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic [7:0] m_cur = '0;
    bit m_active = 1'b0;
    int m_pos = 0;
    bit m_acc;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: a frame is 10*C cycles; position p shows start, data bit p/C-1, or stop
    function automatic int m_tx();
        if (!m_active) return 1;
        if (m_pos < C) return 0;
        if (m_pos < 9 * C) return int'(m_cur[m_pos / C - 1]);
        return 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_pos = 0;
        end else begin
            m_acc = in_valid && mq.size() < D;
            if (!m_active || m_pos == FL - 1) begin
                if (mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    m_active = 1'b1;
                    m_pos = 0;
                end else m_active = 1'b0;
            end else m_pos++;
            if (m_acc) mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        check("tx", int'(tx), m_tx());
        check("busy", int'(busy), int'(m_active));
        check("fifo_count", int'(fifo_count), mq.size());
        check("in_ready", int'(in_ready), int'(mq.size() != D));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, output int w);
        in_valid = 1'b1;
        in_data = b;
        w = 0;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || fifo_count != 0) && n < 1000) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(busy || fifo_count != 0), 0);
    endtask

    task automatic frame_check(input logic [7:0] b, input logic [9:0] bits, input string nm);
        int w, nb;
        push(b, w);
        tick();
        nb = 0;
        for (int i = 0; i < FL; i++) begin
            check($sformatf("%s_c%0d", nm, i), int'(tx), int'(bits[i / C]));
            nb += int'(busy);
            tick();
        end
        check({nm, "_busy_cycles"}, nb, 40);
        check({nm, "_end_busy"}, int'(busy), 0);
        check({nm, "_end_tx"}, int'(tx), 1);
    endtask

    task automatic capture(output logic [7:0] b);
        b = '0;
        for (int i = 0; i < FL; i++) begin
            if (i % C == C / 2 && i / C >= 1 && i / C <= 8) b[i / C - 1] = tx;
            tick();
        end
    endtask

    initial begin
        int w, n, nb;
        logic [7:0] got;
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        tick();

        frame_check(8'h55, 10'b1_01010101_0, "f55");
        frame_check(8'h80, 10'b1_10000000_0, "f80");

        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), w);
        check("fill_count", int'(fifo_count), 4);
        check("fill_ready", int'(in_ready), 0);
        push(8'h15, w);
        check("fill_holdoff", w, 37);
        wait_idle();

        push(8'hA3, w);
        push(8'h0F, w);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        check("b2b_cycles", n, 80);
        wait_idle();

        push(8'hFF, w);
        push(8'h11, w);
        push(8'h22, w);
        check("mid_count", int'(fifo_count), 2);
        repeat (16) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_tx", int'(tx), 1);
        check("mid_rst_count", int'(fifo_count), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        tick();
        tick();
        rst = 1'b0;
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            nb += int'(busy) + int'(!tx);
            tick();
        end
        check("post_rst_quiet", nb, 0);

        push(8'h01, w);
        push(8'h02, w);
        push(8'h03, w);
        n = 0;
        while (!(m_active && m_pos == FL - 1) && n < 100) begin
            tick();
            n++;
        end
        check("sim_reach", int'(m_active && m_pos == FL - 1), 1);
        in_valid = 1'b1;
        in_data = 8'h04;
        tick();
        in_valid = 1'b0;
        check("sim_count", int'(fifo_count), 2);
        capture(got);
        check("sim_oldest", int'(got), 8'h02);
        wait_idle();

        for (int i = 0; i < 2000; i++) begin
            in_valid = (i < 1000) ? ($urandom_range(3) == 0) : ($urandom_range(49) == 0);
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
